block_mem_responder: RTL

- Memory-side responder for the data cache's line fill and writeback traffic.
- Serves one whole-block read or write per transaction over a valid/ready request and response handshake.
- Memory latency is fixed and programmable.
- Sits between the data cache controller, which is the initiator, and the backing block-organised data store, which is internal to this block.

---
 rtl/block_mem_responder_pkg.sv | 16 +
 rtl/block_mem_responder_if.sv | 27 ++
 rtl/block_mem_array.sv | 26 ++
 rtl/block_mem_responder.sv | 128 ++++++++++++
 4 files changed

// File: rtl/block_mem_responder_pkg.sv
// Shared definitions for the block memory responder: block/word widths and FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package block_mem_responder_pkg;

    localparam int BLOCK_SIZE       = 256;  // bits per cache block (32 bytes)
    localparam int WORD_SIZE        = 32;   // address width
    localparam int CACHE_OFFSET_LEN = 5;    // byte-offset bits inside a block

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/block_mem_responder_if.sv
// Request/response bundle between the data cache (master) and the block memory responder (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface block_mem_responder_if;
    import block_mem_responder_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [WORD_SIZE-1:0]  req_addr;
    logic [BLOCK_SIZE-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [BLOCK_SIZE-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/block_mem_array.sv
// Single-port block RAM holding whole cache blocks.
// Latency: write and read both registered, read data valid one edge after idx is presented.
// Backpressure: none; accepts an access every cycle.
module block_mem_array
    import block_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [BLOCK_SIZE-1:0] wdata,
    output logic [BLOCK_SIZE-1:0] rdata
);

    logic [BLOCK_SIZE-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Storage write plus registered (read-before-write) read of the addressed block.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/block_mem_responder.sv
// Memory-side responder serving one whole-block read or write per transaction; BLOCK_MEM_ERR_EN enables out-of-range error reporting.
// Latency: resp_valid rises LATENCY edges after the request is accepted (LATENCY legal range 1..15).
// Backpressure: req_ready only in IDLE; the response is held stable until resp_valid && resp_ready.
module block_mem_responder
    import block_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    block_mem_responder_if.slave bus
);

    localparam int CW     = 4;
    localparam int IDX_HI = CACHE_OFFSET_LEN + DEPTH_LOG2 - 1;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         count;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DEPTH_LOG2-1:0] arr_idx;
    logic                  write_q;
    logic                  oor_q;
    logic                  req_oor;
    logic [BLOCK_SIZE-1:0] wdata_q;
    logic [BLOCK_SIZE-1:0] arr_rdata;
    logic [BLOCK_SIZE-1:0] rdata_q;
    logic                  accept;
    logic                  access;
    logic                  arr_we;
    logic                  unused_addr;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;

    assign accept = bus.req_valid && (state == IDLE);
    assign access = (state == BUSY) && (count == '0);

`ifdef BLOCK_MEM_ERR_EN
    logic err_q;

    assign req_oor      = |bus.req_addr[WORD_SIZE-1:IDX_HI+1];
    assign unused_addr  = ^bus.req_addr[CACHE_OFFSET_LEN-1:0];
    assign bus.resp_err = err_q;

    // Error flag is produced with the response and retired by its handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= oor_q;
        end else if ((state == RESP) && bus.resp_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    // Upper address bits alias into the array.
    assign req_oor      = 1'b0;
    assign unused_addr  = ^{bus.req_addr[WORD_SIZE-1:IDX_HI+1], bus.req_addr[CACHE_OFFSET_LEN-1:0]};
    assign bus.resp_err = 1'b0;
`endif

    // The array is addressed from the live request while idle so its registered
    // read is already settled by the access edge, even for LATENCY=1. Only one
    // transaction is outstanding, so the block cannot change in between.
    assign arr_idx = (state == IDLE) ? bus.req_addr[IDX_HI:CACHE_OFFSET_LEN] : idx_q;
    assign arr_we  = access && write_q && !oor_q;

    block_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, count down in BUSY, wait for handshake in RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid)    state_nxt = BUSY;
            BUSY:    if (count == '0)      state_nxt = RESP;
            RESP:    if (bus.resp_ready)   state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Request capture; no reset needed since it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= bus.req_addr[IDX_HI:CACHE_OFFSET_LEN];
            write_q <= bus.req_write;
            wdata_q <= bus.req_wdata;
            oor_q   <= req_oor;
        end
    end

    // Latency counter and response data; rdata holds the last response outside the access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                count <= CW'(LATENCY - 1);
            end else if ((state == BUSY) && (count != '0)) begin
                count <= count - 1'b1;
            end
            if (access) begin
                rdata_q <= oor_q ? '0 : (write_q ? wdata_q : arr_rdata);
            end
        end
    end

endmodule
